// File: rtl/booth_r4_multiplier_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_r4_multiplier_if : start/busy/done handshake and operand/result bus
// Revision 1.0
// ---------------------------------------------------------------------------
interface booth_r4_multiplier_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] multiplicand;
   logic [WIDTH-1:0] multiplier;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result_hi;
   logic [WIDTH-1:0] result_lo;

   modport master (
      output start, is_signed, multiplicand, multiplier,
      input  busy, done, result_hi, result_lo
   );

   modport slave (
      input  start, is_signed, multiplicand, multiplier,
      output busy, done, result_hi, result_lo
   );
endinterface
`default_nettype wire

// File: rtl/booth_r4_multiplier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_r4_multiplier : sequential radix-4 Booth multiplier, one bit-pair/clock
// Revision 1.0
// ---------------------------------------------------------------------------
module booth_r4_multiplier #(
   parameter int WIDTH = 32
) (
   input wire logic              clock,
   input wire logic              clear,
   booth_r4_multiplier_if.slave  bus
);
   localparam int N_ITER = WIDTH / 2 + 1;
   localparam int CW     = $clog2(N_ITER + 1);
   localparam int AW     = WIDTH + 4;
   localparam int QW     = WIDTH + 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [AW-1:0]    r_acc;
   logic [QW-1:0]    r_q;
   logic             r_qm1;
   logic [QW-1:0]    r_m;
   logic [CW-1:0]    r_cnt;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   logic [AW-1:0]    w_m1;
   logic [AW-1:0]    w_m2;
   logic [AW-1:0]    w_addend;
   logic [AW-1:0]    w_sum;
   logic [AW-1:0]    w_acc_nx;
   logic [QW-1:0]    w_q_nx;
   logic [QW-1:0]    w_m_cap;
   logic [QW-1:0]    w_q_cap;
   logic             w_ext_m;
   logic             w_ext_q;

   // Operands are widened by two bits so one signed Booth datapath covers unsigned mode too
   assign w_ext_m = bus.is_signed & bus.multiplicand[WIDTH-1];
   assign w_ext_q = bus.is_signed & bus.multiplier[WIDTH-1];
   assign w_m_cap = {{2{w_ext_m}}, bus.multiplicand};
   assign w_q_cap = {{2{w_ext_q}}, bus.multiplier};

   assign w_m1 = {{2{r_m[QW-1]}}, r_m};
   assign w_m2 = {w_m1[AW-2:0], 1'b0};

   always_comb begin
      w_addend = '0;
      case ({r_q[1:0], r_qm1})
         3'b001, 3'b010: w_addend = w_m1;
         3'b011:         w_addend = w_m2;
         3'b100:         w_addend = -w_m2;
         3'b101, 3'b110: w_addend = -w_m1;
         default:        w_addend = '0;
      endcase
   end

   assign w_sum    = r_acc + w_addend;
   assign w_acc_nx = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
   assign w_q_nx   = {w_sum[1:0], r_q[QW-1:2]};

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_q     <= '0;
         r_qm1   <= 1'b0;
         r_m     <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_m     <= w_m_cap;
                  r_q     <= w_q_cap;
                  r_qm1   <= 1'b0;
                  r_acc   <= '0;
                  r_cnt   <= CW'(N_ITER);
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               r_acc <= w_acc_nx;
               r_q   <= w_q_nx;
               r_qm1 <= r_q[1];
               r_cnt <= r_cnt - CW'(1);
               // Product bits above QW live in the accumulator after the last shift
               if (r_cnt == CW'(1)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_hi    <= {w_acc_nx[WIDTH-3:0], w_q_nx[QW-1:QW-2]};
                  r_lo    <= w_q_nx[WIDTH-1:0];
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.result_hi = r_hi;
   assign bus.result_lo = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_booth_r4_multiplier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_booth_r4_multiplier : scoreboard bench for 32-bit and 8-bit instances
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_booth_r4_multiplier;
   logic clock = 1'b0;
   logic clear = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [63:0] sb32[$];
   logic [15:0] sb8[$];

   booth_r4_multiplier_if #(.WIDTH(32)) b32 ();
   booth_r4_multiplier_if #(.WIDTH(8))  b8 ();

   booth_r4_multiplier #(.WIDTH(32)) u_dut32 (.clock(clock), .clear(clear), .bus(b32));
   booth_r4_multiplier #(.WIDTH(8))  u_dut8  (.clock(clock), .clear(clear), .bus(b8));

   always #5 clock = ~clock;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic launch32(input logic s, input logic [31:0] m, input logic [31:0] q);
      logic [63:0] em, eq;
      em = s ? {{32{m[31]}}, m} : {32'b0, m};
      eq = s ? {{32{q[31]}}, q} : {32'b0, q};
      sb32.push_back(em * eq);
      b32.start = 1'b1;
      b32.is_signed = s;
      b32.multiplicand = m;
      b32.multiplier = q;
      @(posedge clock); #1;
      b32.start = 1'b0;
   endtask

   task automatic wait32(output int cyc, output int bcnt, output logic [63:0] res);
      cyc = 0;
      bcnt = (b32.busy === 1'b1) ? 1 : 0;
      while (b32.done !== 1'b1 && cyc < 40) begin
         @(posedge clock); #1;
         cyc++;
         if (b32.done !== 1'b1 && b32.busy === 1'b1) bcnt++;
      end
      res = {b32.result_hi, b32.result_lo};
   endtask

   task automatic launch8(input logic s, input logic [7:0] m, input logic [7:0] q);
      logic [15:0] em, eq;
      em = s ? {{8{m[7]}}, m} : {8'b0, m};
      eq = s ? {{8{q[7]}}, q} : {8'b0, q};
      sb8.push_back(em * eq);
      b8.start = 1'b1;
      b8.is_signed = s;
      b8.multiplicand = m;
      b8.multiplier = q;
      @(posedge clock); #1;
      b8.start = 1'b0;
   endtask

   task automatic wait8(output int cyc, output logic [15:0] res);
      cyc = 0;
      while (b8.done !== 1'b1 && cyc < 20) begin
         @(posedge clock); #1;
         cyc++;
      end
      res = {b8.result_hi, b8.result_lo};
   endtask

   task automatic test_reset();
      @(posedge clock); #1;
      checks++;
      if ({b32.busy, b32.done, b32.result_hi, b32.result_lo} !== 66'd0) begin
         errors++;
         $display("FAIL reset32: got busy=%b done=%b hi=%h lo=%h expected all zero",
                  b32.busy, b32.done, b32.result_hi, b32.result_lo);
      end
      checks++;
      if ({b8.busy, b8.done, b8.result_hi, b8.result_lo} !== 18'd0) begin
         errors++;
         $display("FAIL reset8: got busy=%b done=%b hi=%h lo=%h expected all zero",
                  b8.busy, b8.done, b8.result_hi, b8.result_lo);
      end
      clear = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_signed_basic();
      int cyc, bcnt;
      logic [63:0] res, exp;
      launch32(1'b1, 32'hFFFFFFF9, 32'h00000003);
      wait32(cyc, bcnt, res);
      exp = sb32.pop_front();
      checks++;
      if (cyc !== 17) begin errors++; $display("FAIL latency_basic: got %0d expected 17", cyc); end
      checks++;
      if (bcnt !== 17) begin errors++; $display("FAIL busy_cycles: got %0d expected 17", bcnt); end
      checks++;
      if (res !== exp || res !== 64'hFFFFFFFF_FFFFFFEB) begin
         errors++; $display("FAIL neg7x3: got %h expected FFFFFFFFFFFFFFEB", res);
      end
      @(posedge clock); #1;
      checks++;
      if (b32.done !== 1'b0 || b32.busy !== 1'b0) begin
         errors++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", b32.done, b32.busy);
      end
   endtask

   task automatic test_all_ones();
      int cyc, bcnt;
      logic [63:0] res, exp;
      launch32(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait32(cyc, bcnt, res);
      exp = sb32.pop_front();
      checks++;
      if (res !== exp || res !== 64'hFFFFFFFE_00000001) begin
         errors++; $display("FAIL unsigned_ones: got %h expected FFFFFFFE00000001", res);
      end
      @(posedge clock); #1;
      launch32(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait32(cyc, bcnt, res);
      exp = sb32.pop_front();
      checks++;
      if (res !== exp || res !== 64'h00000000_00000001) begin
         errors++; $display("FAIL signed_ones: got %h expected 0000000000000001", res);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcnt;
      logic [63:0] res, exp;
      @(posedge clock); #1;
      launch32(1'b1, 32'h80000000, 32'h80000000);
      wait32(cyc, bcnt, res);
      exp = sb32.pop_front();
      checks++;
      if (res !== exp || res !== 64'h40000000_00000000) begin
         errors++; $display("FAIL min_sq: got %h expected 4000000000000000", res);
      end
      launch32(1'b1, 32'd5, 32'd6);
      checks++;
      if (b32.busy !== 1'b1 || b32.done !== 1'b0) begin
         errors++; $display("FAIL b2b_restart: got busy=%b done=%b expected 1 0", b32.busy, b32.done);
      end
      wait32(cyc, bcnt, res);
      exp = sb32.pop_front();
      checks++;
      if (cyc !== 17) begin errors++; $display("FAIL b2b_latency: got %0d expected 17", cyc); end
      checks++;
      if (res !== exp || res !== 64'h1E) begin
         errors++; $display("FAIL b2b_5x6: got %h expected 000000000000001E", res);
      end
   endtask

   task automatic test_start_during_run();
      int cyc, bcnt;
      logic [63:0] res, exp, prev;
      logic stable;
      @(posedge clock); #1;
      prev = {b32.result_hi, b32.result_lo};
      stable = 1'b1;
      launch32(1'b1, 32'd1234, 32'hFFFFFF9D);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            b32.start = 1'b1;
            b32.multiplicand = 32'h7FFFFFFF;
            b32.multiplier = 32'h12345678;
            b32.is_signed = 1'b0;
         end else begin
            b32.start = 1'b0;
         end
         @(posedge clock); #1;
         if ({b32.result_hi, b32.result_lo} !== prev) stable = 1'b0;
      end
      b32.start = 1'b0;
      wait32(cyc, bcnt, res);
      exp = sb32.pop_front();
      checks++;
      if (stable !== 1'b1) begin errors++; $display("FAIL result_hold: got changing result expected held %h", prev); end
      checks++;
      if (cyc + 5 !== 17) begin errors++; $display("FAIL ignore_latency: got %0d expected 17", cyc + 5); end
      checks++;
      if (res !== exp) begin errors++; $display("FAIL ignore_start: got %h expected %h", res, exp); end
   endtask

   task automatic test_clear_mid_run();
      int cyc, bcnt;
      logic [63:0] res, exp;
      @(posedge clock); #1;
      launch32(1'b0, 32'd1000, 32'd2000);
      void'(sb32.pop_back());
      repeat (8) begin @(posedge clock); #1; end
      #2 clear = 1'b1;
      #1;
      checks++;
      if ({b32.busy, b32.done, b32.result_hi, b32.result_lo} !== 66'd0) begin
         errors++;
         $display("FAIL async_clear: got busy=%b done=%b hi=%h lo=%h expected all zero",
                  b32.busy, b32.done, b32.result_hi, b32.result_lo);
      end
      #1 clear = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (b32.busy !== 1'b0) begin errors++; $display("FAIL clear_idle: got busy=%b expected 0", b32.busy); end
      launch32(1'b1, 32'd12, 32'd12);
      wait32(cyc, bcnt, res);
      exp = sb32.pop_front();
      checks++;
      if (res !== exp || res !== 64'h90) begin
         errors++; $display("FAIL after_clear: got %h expected 0000000000000090", res);
      end
   endtask

   task automatic test_clear_and_start();
      @(posedge clock); #1;
      clear = 1'b1;
      b32.start = 1'b1;
      b32.multiplicand = 32'd3;
      b32.multiplier = 32'd4;
      @(posedge clock); #1;
      checks++;
      if (b32.busy !== 1'b0 || b32.done !== 1'b0) begin
         errors++; $display("FAIL clear_wins: got busy=%b done=%b expected 0 0", b32.busy, b32.done);
      end
      b32.start = 1'b0;
      clear = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_width8();
      int cyc;
      logic [15:0] res, exp;
      launch8(1'b1, 8'h80, 8'hFF);
      wait8(cyc, res);
      exp = sb8.pop_front();
      checks++;
      if (cyc !== 5) begin errors++; $display("FAIL w8_latency: got %0d expected 5", cyc); end
      checks++;
      if (res !== exp || res !== 16'h0080) begin
         errors++; $display("FAIL w8_min_x_neg1: got %h expected 0080", res);
      end
      @(posedge clock); #1;
   endtask

   function automatic logic [31:0] pick32();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'h7FFFFFFF;
         default: return $urandom();
      endcase
   endfunction

   task automatic test_random_sweep();
      int cyc, bcnt, c8;
      logic [63:0] res, exp;
      logic [15:0] r8, e8;
      for (int n = 0; n < 500; n++) begin
         launch32(1'($urandom_range(0, 1)), pick32(), pick32());
         wait32(cyc, bcnt, res);
         exp = sb32.pop_front();
         checks++;
         if (res !== exp || cyc !== 17) begin
            errors++; $display("FAIL rand32_%0d: got %h after %0d cycles expected %h after 17", n, res, cyc, exp);
         end
      end
      for (int n = 0; n < 500; n++) begin
         launch8(1'($urandom_range(0, 1)), 8'($urandom()), 8'($urandom()));
         wait8(c8, r8);
         e8 = sb8.pop_front();
         checks++;
         if (r8 !== e8 || c8 !== 5) begin
            errors++; $display("FAIL rand8_%0d: got %h after %0d cycles expected %h after 5", n, r8, c8, e8);
         end
      end
      checks++;
      if (sb32.size() != 0 || sb8.size() != 0) begin
         errors++; $display("FAIL scoreboard_empty: got %0d/%0d entries expected 0/0", sb32.size(), sb8.size());
      end
   endtask

   initial begin
      b32.start = 1'b0; b32.is_signed = 1'b0; b32.multiplicand = '0; b32.multiplier = '0;
      b8.start = 1'b0;  b8.is_signed = 1'b0;  b8.multiplicand = '0;  b8.multiplier = '0;
      test_reset();
      test_signed_basic();
      test_all_ones();
      test_back_to_back();
      test_start_during_run();
      test_clear_mid_run();
      test_clear_and_start();
      test_width8();
      test_random_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/booth_r4_multiplier.md
Name: booth_r4_multiplier

Overview:
- Parametrised sequential signed/unsigned multiplier using radix-4 Booth (bit-pair) recoding.
- Retires one multiplier bit-pair per clock and produces a 2*WIDTH-bit product split into hi/lo halves for the datapath's HI/LO registers.
- Uses a start/busy/done handshake with the control unit.
- Replaces the single-width multiplier with a generic WIDTH and a signed/unsigned mode.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- N_ITER, WIDTH/2+1, localparam; number of bit-pair iterations. Operands are extended by 2 bits, so this covers both modes.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  asynchronous active-high reset
- start  input  1  request; sampled at a rising edge while in IDLE or DONE
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- multiplicand  input  WIDTH  M; sampled with start
- multiplier  input  WIDTH  Q; sampled with start
- busy  output  1  high in RUN
- done  output  1  single-cycle pulse when the product is valid
- result_hi  output  WIDTH  upper half of the product
- result_lo  output  WIDTH  lower half of the product

Behaviour:
- Reset (clear=1, asynchronous, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, result_hi=0, result_lo=0.
  - Internal accumulator, multiplier shift register and counter are cleared; the in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge captures the operands and moves to RUN.
  - Capture: M extended to WIDTH+2 bits (sign-extended if is_signed, else zero-extended), Q extended the same way, Q[-1]=0, accumulator=0, counter=N_ITER.
- RUN, each edge:
  - Examine the triplet {Q[1],Q[0],Q[-1]}: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Add the selected value to the accumulator (WIDTH+4 bits internally so 2M cannot overflow).
  - Arithmetic-shift {acc,Q,Q[-1]} right by 2; decrement the counter.
  - When the counter reaches 1 at the edge, the final iteration completes, the product is written to result_hi/result_lo, and the state moves to DONE.
- Latency: with the start edge as E0, iterations occur at E1..E_N_ITER. done=1 during the cycle following E_N_ITER, i.e. N_ITER cycles after start (17 for WIDTH=32).
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: start=1 captures new operands and goes to RUN (back-to-back, no idle bubble); otherwise goes to IDLE.
- busy=1 only in RUN. start during RUN is ignored; no queuing and no restart.
- result_hi/result_lo update only at the completing edge and hold until the next completion or clear. They never show partial products.
- Arithmetic:
  - The product is the exact 2*WIDTH-bit result; no overflow is possible.
  - In signed mode the product is a two's-complement 2*WIDTH-bit value.
  - In unsigned mode it is the unsigned 2*WIDTH-bit value; e.g. MSB-set operands are treated as large positives.
- Operand changes after the start edge have no effect on the operation in flight.
- Simultaneous clear and start: clear wins; state stays IDLE.

Test Plan:
- WIDTH=32, is_signed=1, M=0xFFFFFFF9 (-7), Q=0x00000003 -> after 17 cycles done pulses one cycle; result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB; busy high exactly 17 cycles.
- WIDTH=32, is_signed=0, M=Q=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001; the same operands with is_signed=1 give hi=0x00000000, lo=0x00000001.
- WIDTH=32, is_signed=1, M=Q=0x80000000 -> hi=0x40000000, lo=0x00000000. Then start held high in the DONE cycle with M=5, Q=6 -> second done exactly 17 cycles later with hi=0, lo=0x1E.
- start pulsed again mid-RUN with different operands -> ignored; the first product is delivered on schedule and unchanged.
- clear asserted asynchronously (between edges) at iteration 8 -> busy, done and result drop to 0 immediately; a subsequent start computes 12*12 = hi 0, lo 0x90 correctly.
- WIDTH=8 instance, is_signed=1, M=0x80, Q=0xFF -> done after 5 cycles, hi=0x00, lo=0x80. Randomised signed/unsigned sweep against a reference model, 1000 vectors, zero mismatches.
